// File: rtl/ppu_frame_timer.sv
// PPU raster timing: dot/line counters, fetch/scroll strobes, VBlank/NMI.
// Optional PPU_TIMING_LINE_IRQ_EN adds irqLine/irqAck/lineIrq scanline IRQ.
// Ports: clock, reset_n, clock_EN, render_EN, nmi_EN, statusRead in;
//   dot, line, vblank, nmi, oddFrame, frameCount, fetch/scroll strobes out.
module ppu_frame_timer #(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VISIBLE_LINES   = 240,
  parameter int VBLANK_LINE     = 241,
  parameter int ODD_SKIP        = 1,
  parameter int FRAME_W         = 8,
  localparam int XW = $clog2(DOTS_PER_LINE),
  localparam int YW = $clog2(LINES_PER_FRAME)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clock_EN,
  input  logic               render_EN,
  input  logic               nmi_EN,
  input  logic               statusRead,
  output logic [XW-1:0]      dot,
  output logic [YW-1:0]      line,
  output logic               vblank,
  output logic               nmi,
  output logic               oddFrame,
  output logic [FRAME_W-1:0] frameCount,
`ifdef PPU_TIMING_LINE_IRQ_EN
  input  logic [YW-1:0]      irqLine,
  input  logic               irqAck,
  output logic               lineIrq,
`endif
  output logic               bgFetch_EN,
  output logic               spriteFetch_EN,
  output logic               spriteEval_EN,
  output logic               incrementX,
  output logic               incrementY,
  output logic               resetX,
  output logic               resetY
);

  localparam logic [XW-1:0] DLAST = XW'(DOTS_PER_LINE - 1);
  localparam logic [YW-1:0] LLAST = YW'(LINES_PER_FRAME - 1);
  localparam logic [YW-1:0] LVIS  = YW'(VISIBLE_LINES);
  localparam logic [YW-1:0] LVBL  = YW'(VBLANK_LINE);

  logic [XW-1:0]      dot_q, dot_d;
  logic [YW-1:0]      line_q, line_d;
  logic               odd_q, odd_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               vbl_q, vbl_d;
  logic               nmi_q, nmi_d;
  logic [6:0]         stb_q, stb_d;

  logic vis, pre, act, in256, inspr, inbg, inry;

  always_comb begin
    dot_d   = dot_q;
    line_d  = line_q;
    odd_d   = odd_q;
    frame_d = frame_q;
    if (clock_EN) begin
      if (dot_q == DLAST) begin
        dot_d = '0;
        if (line_q == LLAST) begin
          line_d  = '0;
          odd_d   = ~odd_q;
          frame_d = frame_q + FRAME_W'(1);
          // odd frame ends one dot short while rendering
          if (ODD_SKIP != 0 && odd_q && render_EN)
            dot_d = XW'(1);
        end else begin
          line_d = line_q + YW'(1);
        end
      end else begin
        dot_d = dot_q + XW'(1);
      end
    end
  end

  assign vis   = line_q < LVIS;
  assign pre   = line_q == LLAST;
  assign act   = vis | pre;
  assign in256 = dot_q >= XW'(1) && dot_q <= XW'(256);
  assign inspr = dot_q >= XW'(257) && dot_q <= XW'(320);
  assign inbg  = in256 || dot_q >= XW'(321);
  assign inry  = dot_q >= XW'(280) && dot_q <= XW'(304);

  // bit order: bg, sprFetch, eval, incX, incY, resX, resY
  always_comb begin
    stb_d = stb_q;
    if (clock_EN) begin
      stb_d[6] = render_EN && act && inbg;
      stb_d[5] = render_EN && act && inspr;
      stb_d[4] = render_EN && vis && in256;
      stb_d[3] = render_EN && act &&
                 ((dot_q[2:0] == 3'd0 && in256) ||
                  dot_q == XW'(328) || dot_q == XW'(336));
      stb_d[2] = render_EN && act && dot_q == XW'(256);
      stb_d[1] = render_EN && act && dot_q == XW'(257);
      stb_d[0] = render_EN && pre && inry;
    end
  end

  // a status read on the set clock wins, suppressing this frame's flag
  always_comb begin
    vbl_d = vbl_q;
    if (clock_EN && dot_q == XW'(1) && line_q == LVBL)
      vbl_d = 1'b1;
    if ((clock_EN && dot_q == XW'(1) && pre) || statusRead)
      vbl_d = 1'b0;
    nmi_d = vbl_q & nmi_EN;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dot_q   <= '0;
      line_q  <= '0;
      odd_q   <= 1'b0;
      frame_q <= '0;
      vbl_q   <= 1'b0;
      nmi_q   <= 1'b0;
      stb_q   <= '0;
    end else begin
      dot_q   <= dot_d;
      line_q  <= line_d;
      odd_q   <= odd_d;
      frame_q <= frame_d;
      vbl_q   <= vbl_d;
      nmi_q   <= nmi_d;
      stb_q   <= stb_d;
    end
  end

`ifdef PPU_TIMING_LINE_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (clock_EN && render_EN && dot_q == XW'(260) && line_q == irqLine)
      irq_d = 1'b1;
    if (irqAck)
      irq_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign lineIrq = irq_q;
`endif

  assign dot            = dot_q;
  assign line           = line_q;
  assign vblank         = vbl_q;
  assign nmi            = nmi_q;
  assign oddFrame       = odd_q;
  assign frameCount     = frame_q;
  assign bgFetch_EN     = stb_q[6];
  assign spriteFetch_EN = stb_q[5];
  assign spriteEval_EN  = stb_q[4];
  assign incrementX     = stb_q[3];
  assign incrementY     = stb_q[2];
  assign resetX         = stb_q[1];
  assign resetY         = stb_q[0];

endmodule

// File: tb/tb_ppu_frame_timer.sv
// Directed bench for ppu_frame_timer on a short 341x20 frame.
// Visible lines 0..11, VBlank line 13, pre-render line 19.
module tb_ppu_frame_timer;

  localparam int XW = 9;
  localparam int YW = 5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clock_EN = 1'b1;
  logic          render_EN = 1'b0;
  logic          nmi_EN = 1'b0;
  logic          statusRead = 1'b0;
  logic [XW-1:0] dot;
  logic [YW-1:0] line;
  logic          vblank, nmi, oddFrame;
  logic [7:0]    frameCount;
  logic          bgFetch_EN, spriteFetch_EN, spriteEval_EN;
  logic          incrementX, incrementY, resetX, resetY;
`ifdef PPU_TIMING_LINE_IRQ_EN
  logic [YW-1:0] irqLine = 5'd5;
  logic          irqAck = 1'b0;
  logic          lineIrq;
`endif

  int checks = 0;
  int errors = 0;
  int cnt[7];
  logic [6:0] stb;

  assign stb = {bgFetch_EN, spriteFetch_EN, spriteEval_EN,
                incrementX, incrementY, resetX, resetY};

  ppu_frame_timer #(
    .DOTS_PER_LINE(341), .LINES_PER_FRAME(20), .VISIBLE_LINES(12),
    .VBLANK_LINE(13), .ODD_SKIP(1), .FRAME_W(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .clock_EN(clock_EN),
    .render_EN(render_EN), .nmi_EN(nmi_EN), .statusRead(statusRead),
    .dot(dot), .line(line), .vblank(vblank), .nmi(nmi),
    .oddFrame(oddFrame), .frameCount(frameCount),
`ifdef PPU_TIMING_LINE_IRQ_EN
    .irqLine(irqLine), .irqAck(irqAck), .lineIrq(lineIrq),
`endif
    .bgFetch_EN(bgFetch_EN), .spriteFetch_EN(spriteFetch_EN),
    .spriteEval_EN(spriteEval_EN), .incrementX(incrementX),
    .incrementY(incrementY), .resetX(resetX), .resetY(resetY)
  );

  always #5 clock = ~clock;

  task automatic adv(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic count_line();
    for (int j = 0; j < 7; j++) cnt[j] = 0;
    for (int i = 0; i < 341; i++) begin
      adv(1);
      for (int j = 0; j < 7; j++) cnt[j] += int'(stb[j]);
    end
  endtask

  initial begin
    #3;
    chk("reset_all", 64'({dot, line, vblank, nmi, oddFrame,
                          frameCount, stb}), 64'd0);
    reset_n = 1'b1;

    adv(340);
    chk("dot340", 64'(dot), 64'd340);
    adv(1);
    chk("wrap_dot", 64'(dot), 64'd0);
    chk("wrap_line", 64'(line), 64'd1);
    adv(6478);
    chk("last_pos", 64'({dot, line}), 64'({9'd340, 5'd19}));
    adv(1);
    chk("f1_pos", 64'({dot, line}), 64'd0);
    chk("f1_cnt", 64'(frameCount), 64'd1);
    chk("f1_odd", 64'(oddFrame), 64'd1);
    adv(6820);
    chk("f2_pos_noskip", 64'({dot, line}), 64'd0);
    chk("f2_cnt", 64'(frameCount), 64'd2);
    chk("f2_odd", 64'(oddFrame), 64'd0);
    chk("nmi_off", 64'(nmi), 64'd0);

    render_EN = 1'b1;
    nmi_EN = 1'b1;
    adv(3410);
    count_line();
    chk("l10_bg", 64'(cnt[6]), 64'd276);
    chk("l10_sf", 64'(cnt[5]), 64'd64);
    chk("l10_eval", 64'(cnt[4]), 64'd256);
    chk("l10_incx", 64'(cnt[3]), 64'd34);
    chk("l10_incy", 64'(cnt[2]), 64'd1);
    chk("l10_resx", 64'(cnt[1]), 64'd1);
    chk("l10_resy", 64'(cnt[0]), 64'd0);

    adv(682);
    adv(1);
    chk("vbl_pre", 64'(vblank), 64'd0);
    adv(1);
    chk("vbl_set", 64'(vblank), 64'd1);
    chk("nmi_lag", 64'(nmi), 64'd0);
    adv(1);
    chk("nmi_set", 64'(nmi), 64'd1);
    adv(338);
    count_line();
    chk("l14_none", 64'(cnt[0] + cnt[1] + cnt[2] + cnt[3] +
                        cnt[4] + cnt[5] + cnt[6]), 64'd0);

    clock_EN = 1'b0;
    statusRead = 1'b1;
    adv(1);
    statusRead = 1'b0;
    chk("rd_clear", 64'(vblank), 64'd0);
    chk("hold_pos", 64'({dot, line}), 64'({9'd0, 5'd15}));
    adv(1);
    chk("nmi_clear", 64'(nmi), 64'd0);
    clock_EN = 1'b1;

    adv(1364);
    count_line();
    chk("pre_resy", 64'(cnt[0]), 64'd25);
    chk("pre_incx", 64'(cnt[3]), 64'd34);
    chk("f3_pos", 64'({dot, line}), 64'd0);
    chk("f3_cnt", 64'(frameCount), 64'd3);

    adv(4774);
    chk("f3_vbl", 64'(vblank), 64'd1);
    adv(2045);
    chk("f3_last", 64'({dot, line}), 64'({9'd340, 5'd19}));
    chk("pre_clear", 64'(vblank), 64'd0);
    adv(1);
    chk("odd_skip", 64'({dot, line}), 64'({9'd1, 5'd0}));
    chk("f4_cnt", 64'(frameCount), 64'd4);

    adv(4433);
    statusRead = 1'b1;
    adv(1);
    statusRead = 1'b0;
    chk("race_vbl", 64'(vblank), 64'd0);
    adv(1);
    chk("race_nmi", 64'(nmi), 64'd0);
    adv(2384);
    chk("f5_pos", 64'({dot, line}), 64'd0);
    chk("race_hold", 64'(vblank), 64'd0);
    adv(4434);
    chk("f5_vbl_pre", 64'(vblank), 64'd0);
    adv(1);
    chk("f5_vbl_set", 64'(vblank), 64'd1);

    adv(2144);
    chk("mid_bg", 64'(bgFetch_EN), 64'd1);
    chk("mid_vbl", 64'(vblank), 64'd0);
    render_EN = 1'b0;
    adv(1);
    chk("drop_bg", 64'(bgFetch_EN), 64'd0);
    chk("drop_dot", 64'(dot), 64'd101);

    render_EN = 1'b1;
    adv(240);
    chk("f6_skip", 64'({dot, line}), 64'({9'd1, 5'd0}));

`ifdef PPU_TIMING_LINE_IRQ_EN
    adv(1964);
    chk("irq_pre", 64'(lineIrq), 64'd0);
    adv(1);
    chk("irq_set", 64'(lineIrq), 64'd1);
    adv(10);
    chk("irq_hold", 64'(lineIrq), 64'd1);
    irqAck = 1'b1;
    adv(1);
    irqAck = 1'b0;
    chk("irq_ack", 64'(lineIrq), 64'd0);
    render_EN = 1'b0;
    irqLine = 5'd6;
    adv(341);
    chk("irq_norender", 64'(lineIrq), 64'd0);
    render_EN = 1'b1;
`endif

    adv(50);
    reset_n = 1'b0;
    #2;
    chk("areset_all", 64'({dot, line, vblank, nmi, oddFrame,
                           frameCount, stb}), 64'd0);
`ifdef PPU_TIMING_LINE_IRQ_EN
    chk("areset_irq", 64'(lineIrq), 64'd0);
`endif
    #2;
    reset_n = 1'b1;
    adv(1);
    chk("restart", 64'({dot, line, frameCount}), 64'({9'd1, 5'd0, 8'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
